// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter and its downstream observers.
// Holds the monitor FSM encoding, the config register selects and the default width.
package prog_counter_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INSIDE = 2'd2,
    DONE   = 2'd3
  } mon_state_e;

  localparam logic [1:0] CFG_SEL_LO    = 2'd0;
  localparam logic [1:0] CFG_SEL_HI    = 2'd1;
  localparam logic [1:0] CFG_SEL_LIMIT = 2'd2;

endpackage

// File: rtl/count_window_cmp.sv
// Window comparator: LO/HI/LIMIT registers, sampled count and the registered
// in-window flag together with its one-cycle-delayed copy for entry detection.
module count_window_cmp
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_i,
  input  logic             cfg_wr_i,
  input  logic [1:0]       cfg_sel_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] limit_o,
  output logic             in_win_o,
  output logic             in_win_prev_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             in_win_now_q, in_win_now_d;
  logic             in_win_q, in_win_d;

  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    limit_d = limit_q;
    if (cfg_wr_i) begin
      case (cfg_sel_i)
        CFG_SEL_LO:    lo_d    = cfg_data_i;
        CFG_SEL_HI:    hi_d    = cfg_data_i;
        CFG_SEL_LIMIT: limit_d = cfg_data_i;
        default:       ;
      endcase
    end
    count_d      = count_i;
    // LO > HI can never satisfy both bounds, so an inverted window stays empty.
    in_win_now_d = (count_q >= lo_q) && (count_q <= hi_q);
    in_win_d     = in_win_now_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      limit_q      <= '0;
      in_win_now_q <= 1'b0;
      in_win_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      limit_q      <= limit_d;
      in_win_now_q <= in_win_now_d;
      in_win_q     <= in_win_d;
    end
  end

  assign count_o       = count_q;
  assign limit_o       = limit_q;
  assign in_win_o      = in_win_now_q;
  assign in_win_prev_o = in_win_q;

endmodule

// File: rtl/count_window_monitor.sv
// Counter window monitor: counts window entries, raises a sticky irq after LIMIT
// entries; optional max-to-zero wrap pulse when COUNT_WINDOW_WRAP_DETECT_EN is defined.
module count_window_monitor
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_i,
  input  logic             cfg_wr_i,
  input  logic [1:0]       cfg_sel_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             arm_i,
  input  logic             clr_i,
  output logic             in_window_o,
  output logic             match_pulse_o,
  output logic             wrap_pulse_o,
  output logic [WIDTH-1:0] event_cnt_o,
  output logic             irq_o,
  output logic [1:0]       state_o
);

  logic [WIDTH-1:0] samp_count;
  logic [WIDTH-1:0] win_limit;
  logic             in_win;
  logic             in_win_prev;

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] event_cnt_q, event_cnt_d;
  logic             irq_q, irq_d;
  logic             entry;
  logic             match_fire;
  logic             below_limit;

  count_window_cmp #(.WIDTH(WIDTH)) u_cmp (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_i       (count_i),
    .cfg_wr_i      (cfg_wr_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_data_i    (cfg_data_i),
    .count_o       (samp_count),
    .limit_o       (win_limit),
    .in_win_o      (in_win),
    .in_win_prev_o (in_win_prev)
  );

  assign entry       = in_win && !in_win_prev;
  assign match_fire  = (state_q == ARMED) && arm_i && !clr_i && entry;
  assign below_limit = (win_limit == '0) || (event_cnt_q < win_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (arm_i) state_d = ARMED;
        ARMED:  if (!arm_i) state_d = IDLE;
                else if (entry) state_d = INSIDE;
        // LIMIT is only judged on the way out, so a late LIMIT write lands on the next exit.
        INSIDE: if (!arm_i) state_d = IDLE;
                else if (!in_win) state_d = below_limit ? ARMED : DONE;
        DONE:   state_d = DONE;
      endcase
    end
  end

  always_comb begin
    event_cnt_d = event_cnt_q;
    irq_d       = irq_q;
    if (clr_i) begin
      event_cnt_d = '0;
      irq_d       = 1'b0;
    end else begin
      if (match_fire && (event_cnt_q != '1)) event_cnt_d = event_cnt_q + 1'b1;
      if (state_d == DONE) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      event_cnt_q <= event_cnt_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    in_window_o   = in_win;
    match_pulse_o = match_fire;
    event_cnt_o   = event_cnt_q;
    irq_o         = irq_q;
    state_o       = state_q;
  end

`ifdef COUNT_WINDOW_WRAP_DETECT_EN
  logic [WIDTH-1:0] count_prev_q, count_prev_d;
  logic             wrap_q, wrap_d;

  // Registered alongside in_win so the pulse lines up with in_window_o.
  always_comb begin
    count_prev_d = samp_count;
    wrap_d       = (count_prev_q == '1) && (samp_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_prev_q <= '0;
      wrap_q       <= 1'b0;
    end else begin
      count_prev_q <= count_prev_d;
      wrap_q       <= wrap_d;
    end
  end

  assign wrap_pulse_o = wrap_q;
`else
  logic unused_samp_count;
  assign unused_samp_count = ^samp_count;
  assign wrap_pulse_o      = 1'b0;
`endif

endmodule

// File: tb/tb_count_window_monitor.sv
// Directed self-checking bench for count_window_monitor with hand-computed expectations.
// Wrap expectations follow COUNT_WINDOW_WRAP_DETECT_EN.
module tb_count_window_monitor;

`ifdef COUNT_WINDOW_WRAP_DETECT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] count_i;
  logic       cfg_wr_i;
  logic [1:0] cfg_sel_i;
  logic [7:0] cfg_data_i;
  logic       arm_i;
  logic       clr_i;
  logic       in_window_o;
  logic       match_pulse_o;
  logic       wrap_pulse_o;
  logic [7:0] event_cnt_o;
  logic       irq_o;
  logic [1:0] state_o;

  int n_checks;
  int n_fail;
  int pulse_cnt;
  int inwin_cnt;
  int wrap_cnt;
  int wrap_total;
  int first_pulse;
  int first_wrap;
  int seq[$];

  count_window_monitor #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_i       (count_i),
    .cfg_wr_i      (cfg_wr_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_data_i    (cfg_data_i),
    .arm_i         (arm_i),
    .clr_i         (clr_i),
    .in_window_o   (in_window_o),
    .match_pulse_o (match_pulse_o),
    .wrap_pulse_o  (wrap_pulse_o),
    .event_cnt_o   (event_cnt_o),
    .irq_o         (irq_o),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
    cfg_wr_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_data_i = data;
    tick();
    cfg_wr_i   = 1'b0;
  endtask

  // Drives seq one value per cycle; outputs seen at step k belong to the value driven at k-2.
  task automatic run_seq(input string tag, input int lo, input int hi);
    int d1;
    int d2;
    d1 = int'(count_i);
    d2 = int'(count_i);
    pulse_cnt   = 0;
    inwin_cnt   = 0;
    wrap_cnt    = 0;
    first_pulse = -1;
    first_wrap  = -1;
    for (int k = 0; k < seq.size() + 2; k++) begin
      check_val({tag, "_in_window"}, int'(in_window_o), (d2 >= lo && d2 <= hi) ? 1 : 0);
      if (match_pulse_o && first_pulse < 0) first_pulse = k;
      if (wrap_pulse_o && first_wrap < 0) first_wrap = k;
      pulse_cnt += int'(match_pulse_o);
      inwin_cnt += int'(in_window_o);
      wrap_cnt  += int'(wrap_pulse_o);
      d2 = d1;
      if (k < seq.size()) count_i = 8'(seq[k]);
      d1 = int'(count_i);
      tick();
    end
    wrap_total += wrap_cnt;
    $display("%s: pulses=%0d in_window_cycles=%0d wraps=%0d event_cnt=%0d state=%0d irq=%0d",
             tag, pulse_cnt, inwin_cnt, wrap_cnt, event_cnt_o, state_o, irq_o);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    wrap_total = 0;
    rst_n      = 1'b1;
    count_i    = 8'd0;
    cfg_wr_i   = 1'b0;
    cfg_sel_i  = 2'd0;
    cfg_data_i = 8'd0;
    arm_i      = 1'b0;
    clr_i      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_in_window", int'(in_window_o), 0);
    check_val("rst_match", int'(match_pulse_o), 0);
    check_val("rst_wrap", int'(wrap_pulse_o), 0);
    check_val("rst_event_cnt", int'(event_cnt_o), 0);
    check_val("rst_irq", int'(irq_o), 0);
    check_val("rst_state", int'(state_o), 0);
    $display("reset: outputs sampled during reset");
    #19 rst_n = 1'b1;

    // Window [5,8], unlimited, sweep 0..20.
    cfg(2'd0, 8'd5);
    cfg(2'd1, 8'd8);
    cfg(2'd2, 8'd0);
    tick();
    tick();
    arm_i = 1'b1;
    tick();
    tick();
    check_val("t1_armed", int'(state_o), 1);
    seq.delete();
    for (int v = 0; v <= 20; v++) seq.push_back(v);
    run_seq("t1", 5, 8);
    check_val("t1_pulses", pulse_cnt, 1);
    check_val("t1_pulse_pos", first_pulse, 7);
    check_val("t1_inwin_cycles", inwin_cnt, 4);
    check_val("t1_event_cnt", int'(event_cnt_o), 1);
    check_val("t1_state", int'(state_o), 1);

    // LIMIT=2, window [3,4], three passes of 0..7.
    arm_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    cfg(2'd0, 8'd3);
    cfg(2'd1, 8'd4);
    cfg(2'd2, 8'd2);
    tick();
    tick();
    arm_i = 1'b1;
    tick();
    check_val("t2_armed", int'(state_o), 1);
    seq.delete();
    for (int p = 0; p < 3; p++)
      for (int v = 0; v <= 7; v++) seq.push_back(v);
    run_seq("t2", 3, 4);
    check_val("t2_pulses", pulse_cnt, 2);
    check_val("t2_inwin_cycles", inwin_cnt, 6);
    check_val("t2_event_cnt", int'(event_cnt_o), 2);
    check_val("t2_irq", int'(irq_o), 1);
    check_val("t2_state", int'(state_o), 3);

    // clr_i and arm_i together in DONE: clear wins, arm takes effect next cycle.
    clr_i = 1'b1;
    arm_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_val("t5_state_idle", int'(state_o), 0);
    check_val("t5_irq", int'(irq_o), 0);
    check_val("t5_event_cnt", int'(event_cnt_o), 0);
    tick();
    check_val("t5_state_armed", int'(state_o), 1);
    $display("t5: clear with arm -> state=%0d", state_o);

    // Empty window LO=9, HI=2, sweep 0..255.
    cfg(2'd0, 8'd9);
    cfg(2'd1, 8'd2);
    cfg(2'd2, 8'd0);
    tick();
    tick();
    seq.delete();
    for (int v = 0; v <= 255; v++) seq.push_back(v);
    run_seq("t3", 9, 2);
    check_val("t3_pulses", pulse_cnt, 0);
    check_val("t3_inwin_cycles", inwin_cnt, 0);
    check_val("t3_state", int'(state_o), 1);

    // Single-value window [10,10] with loads into it.
    arm_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    cfg(2'd0, 8'd10);
    cfg(2'd1, 8'd10);
    tick();
    tick();
    arm_i = 1'b1;
    tick();
    tick();
    seq.delete();
    seq.push_back(0);
    seq.push_back(0);
    seq.push_back(10);
    seq.push_back(11);
    seq.push_back(10);
    seq.push_back(10);
    run_seq("t4", 10, 10);
    check_val("t4_pulses", pulse_cnt, 2);
    check_val("t4_inwin_cycles", inwin_cnt, 3);
    check_val("t4_event_cnt", int'(event_cnt_o), 2);
    check_val("t4_state", int'(state_o), 2);

    // Wrap 254,255,0 fires once; a load 7->0 does not.
    seq.delete();
    seq.push_back(254);
    seq.push_back(255);
    seq.push_back(0);
    seq.push_back(0);
    seq.push_back(7);
    seq.push_back(0);
    seq.push_back(0);
    run_seq("t6", 10, 10);
    check_val("t6_wraps", wrap_cnt, WRAP_EN);
    check_val("t6_wrap_pos", first_wrap, (WRAP_EN != 0) ? 4 : -1);
    check_val("t6_event_cnt", int'(event_cnt_o), 2);
    check_val("wrap_total", wrap_total, 2 * WRAP_EN);

    // Asynchronous reset while inside the window, then quiet release.
    count_i = 8'd10;
    tick();
    tick();
    tick();
    check_val("t7_pre_state", int'(state_o), 2);
    check_val("t7_pre_event_cnt", int'(event_cnt_o), 3);
    #2;
    rst_n = 1'b0;
    arm_i = 1'b0;
    #1;
    check_val("t7_rst_in_window", int'(in_window_o), 0);
    check_val("t7_rst_event_cnt", int'(event_cnt_o), 0);
    check_val("t7_rst_state", int'(state_o), 0);
    check_val("t7_rst_irq", int'(irq_o), 0);
    #2 rst_n = 1'b1;
    pulse_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pulse_cnt += int'(match_pulse_o);
    end
    check_val("t7_post_pulses", pulse_cnt, 0);
    check_val("t7_post_state", int'(state_o), 0);
    check_val("t7_post_event_cnt", int'(event_cnt_o), 0);
    $display("t7: async reset mid-operation, pulses after release=%0d", pulse_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_window_monitor.md
# count_window_monitor

Downstream observer for the 8-bit programmable counter. It samples the counter value each cycle and checks it against a programmable window [LO, HI]. It counts window entries, raises a sticky interrupt after a programmed number of entries, and flags max-to-zero wrap. It lets the top level report counter events on spare outputs without software polling.

## Interface
- WIDTH, 8, width of count and threshold registers
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- count_i  input  WIDTH  counter value from the programmable counter
- cfg_wr_i  input  1  write strobe, one cycle
- cfg_sel_i  input  2  register select: 0=LO, 1=HI, 2=LIMIT, 3=reserved (write ignored)
- cfg_data_i  input  WIDTH  write data
- arm_i  input  1  start monitoring (level sampled each cycle)
- clr_i  input  1  clear event count, irq and state
- in_window_o  output  1  registered: sampled count within [LO, HI]
- match_pulse_o  output  1  one-cycle pulse on window entry while armed
- wrap_pulse_o  output  1  one-cycle pulse on wrap (see Configuration)
- event_cnt_o  output  WIDTH  window entries since last clear
- irq_o  output  1  sticky, set on entering DONE
- state_o  output  2  FSM state, for debug

## Operation
- Stage 1: count_i registered into count_q.
- Stage 2: window compare on count_q, then register. in_win = (count_q >= LO) && (count_q <= HI), unsigned.
- LO > HI means the window is empty: in_win is never 1.
- LO == HI means a single-value window.
- Entry = in_win now && !in_win previous cycle (in_win_q).
- FSM states, encoded in package:
  - IDLE=0: arm_i=1 -> ARMED.
  - ARMED=1: on entry -> INSIDE, match_pulse_o=1, event_cnt+1.
  - INSIDE=2: !in_win -> ARMED if LIMIT==0 or event_cnt<LIMIT; otherwise -> DONE.
  - DONE=3: irq_o=1; holds until clr_i.
- Reaching LIMIT while inside: the FSM waits for the window exit before entering DONE. irq_o is set in the same cycle as the DONE transition.
- LIMIT==0 means unlimited. event_cnt saturates at 2^WIDTH-1 and never wraps.
- arm_i deasserted in ARMED or INSIDE -> IDLE. event_cnt is kept.
- clr_i has priority over everything else. It forces IDLE, event_cnt=0 and irq_o=0. arm_i in the same cycle is ignored.
- Entry while IDLE or DONE: no pulse, no count. in_window_o still tracks.
- Count jumping straight into the window (counter load) counts as an entry, like an increment.
- Config writes update the register at the clock edge and apply from the next compare cycle.
- A write to LIMIT at or below the current event_cnt takes effect on the next window exit.

## Timing
- Reset values: count_q=0, in_win_q=0, LO=0, HI=0, LIMIT=0, state=IDLE.
- All outputs are 0 at reset, including event_cnt_o, irq_o and state_o.
- Latency: count_i change at edge N -> in_window_o and match_pulse_o valid after edge N+2.
- Because reset leaves in_win_q=0, a first compare of count_q=0 against the default window [0,0] registers as an entry.
- match_pulse_o is high for exactly one cycle per entry.
- Minimum entry spacing is 2 cycles (enter, leave, enter).
- Asynchronous reset mid-operation clears all state immediately. No pulse may be emitted on release.

## Configuration
- Macro: COUNT_WINDOW_WRAP_DETECT_EN.
- Defined: wrap_pulse_o fires one cycle (aligned with the in_window_o latency) when count_q goes from all-ones to 0 on consecutive samples. Independent of FSM state.
- Loads that land on 0 from any other value do not fire.
- Undefined: wrap_pulse_o is tied 0. The previous-count register and its compare logic are not built.

## Structure
- Shared package prog_counter_pkg holds:
  - mon_state_e enum (IDLE, ARMED, INSIDE, DONE).
  - CFG_SEL_LO, CFG_SEL_HI and CFG_SEL_LIMIT constants.
  - Default WIDTH.
- Sub-module count_window_cmp contains:
  - The LO/HI/LIMIT register file and its write decode.
  - The registered in_win and in_win_q outputs.
- The top level holds the FSM, event counter, irq and wrap detection.

## Test plan
- Reset, LO=5, HI=8, LIMIT=0, arm, count 0..20 -> one match_pulse_o two cycles after count=5 is sampled; in_window_o high for counts 5..8; event_cnt_o=1.
- LIMIT=2, window [3,4], count cycles 0..7 three times -> match pulses on passes 1 and 2; DONE and irq_o=1 on exit of pass 2; pass 3 gives no pulse and event_cnt_o stays 2.
- LO=9, HI=2 (empty window), count sweeps 0..255 -> in_window_o and match_pulse_o never assert.
- Window [10,10], count jumps 0->10 (load), then 10->11, then jumps 11->10 -> two entries counted.
- clr_i and arm_i asserted in the same cycle while in DONE -> IDLE, irq_o=0, event_cnt_o=0; arming the next cycle enters ARMED.
- With COUNT_WINDOW_WRAP_DETECT_EN: count 254, 255, 0 -> one wrap_pulse_o. A load of 0 from 7 gives none. Without the macro, wrap_pulse_o stays 0 throughout.
